// File: rtl/rect_plot_pkg.sv
// Shared constants and helpers for the rectangle plot arbiter.
// Enabling RECT_PLOT_CLIP_EN suppresses plotting of off-screen pixels.
package rect_plot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int CW      = 3;

    // True when a widened pixel coordinate lies inside the visible screen.
    function automatic logic on_screen(
        input logic [XW:0] sx,
        input logic [YW:0] sy,
        input logic [XW:0] xlim,
        input logic [YW:0] ylim
    );
        return (sx < xlim) && (sy < ylim);
    endfunction

endpackage

// File: rtl/rect_plot_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request after 'last', wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic          found_s;
    logic          hit_s;
    logic [IW-1:0] pos_s;

    // Scan last+1, last+2, ... and keep only the first asserted request.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        pos_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos_s      = IW'((int'(last) + k) % NREQ);
            hit_s      = ~found_s & req[pos_s];
            gnt[pos_s] = gnt[pos_s] | hit_s;
            found_s    = found_s | hit_s;
        end
    end

    // One-hot to index encoder.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = idx | (IW'(i) & {IW{gnt[i]}});
        end
    end

    assign any = |gnt;

endmodule

// File: rtl/rect_plot_arbiter.sv
// Shares the VGA pixel-plot port among NREQ rectangle-fill requesters.
// Define RECT_PLOT_CLIP_EN to emit off-screen pixels with plot low.
module rect_plot_arbiter #(
    parameter int NREQ    = 3,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int DW      = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    rect_x,
    input  logic [7*NREQ-1:0]    rect_y,
    input  logic [DW*NREQ-1:0]   rect_w,
    input  logic [DW*NREQ-1:0]   rect_h,
    input  logic [3*NREQ-1:0]    rect_colour,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 plot
);
    import rect_plot_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [DW-1:0] ONE_DW = DW'(1);
`ifdef RECT_PLOT_CLIP_EN
    localparam logic CLIP_ON = 1'b1;
`else
    localparam logic CLIP_ON = 1'b0;
`endif

    state_t            state_r, state_s;
    logic [IW-1:0]     last_r, last_s;
    logic [XW-1:0]     bx_r, bx_s;
    logic [YW-1:0]     by_r, by_s;
    logic [DW-1:0]     bw_r, bw_s, bh_r, bh_s;
    logic [DW-1:0]     xc_r, xc_s, yc_r, yc_s;
    logic [CW-1:0]     col_r, col_s;
    logic [NREQ-1:0]   grant_r, grant_s, done_r, done_s;
    logic              busy_r, plot_r, plot_s, emit_s;
    logic [XW-1:0]     vga_x_r, vga_x_s;
    logic [YW-1:0]     vga_y_r, vga_y_s;
    logic [CW-1:0]     vga_col_r, vga_col_s;

    logic [NREQ-1:0]   pick_s;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_any_s;
    logic [XW-1:0]     sel_x_s;
    logic [YW-1:0]     sel_y_s;
    logic [DW-1:0]     sel_w_s, sel_h_s;
    logic [CW-1:0]     sel_col_s;
    logic              zero_s, last_pix_s, row_end_s;
    logic [XW:0]       sx_s;
    logic [YW:0]       sy_s;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req  (req),
        .last (last_r),
        .gnt  (pick_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Mux the winner's rectangle fields using the one-hot pick.
    always_comb begin
        sel_x_s   = '0;
        sel_y_s   = '0;
        sel_w_s   = '0;
        sel_h_s   = '0;
        sel_col_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_x_s   = sel_x_s   | (rect_x[i*XW +: XW]      & {XW{pick_s[i]}});
            sel_y_s   = sel_y_s   | (rect_y[i*YW +: YW]      & {YW{pick_s[i]}});
            sel_w_s   = sel_w_s   | (rect_w[i*DW +: DW]      & {DW{pick_s[i]}});
            sel_h_s   = sel_h_s   | (rect_h[i*DW +: DW]      & {DW{pick_s[i]}});
            sel_col_s = sel_col_s | (rect_colour[i*CW +: CW] & {CW{pick_s[i]}});
        end
    end

    assign zero_s     = (sel_w_s == '0) || (sel_h_s == '0);
    assign row_end_s  = (xc_r == bw_r - ONE_DW);
    assign last_pix_s = row_end_s && (yc_r == bh_r - ONE_DW);

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a zero-size grant spends two cycles in DONE (grant, then done).
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s = zero_s ? DONE : DRAW;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAW:    state_s = last_pix_s ? DONE : DRAW;
            DONE:    state_s = (done_r != '0) ? IDLE : DONE;
            default: state_s = IDLE;
        endcase
    end

    // Control and scan-counter next values.
    always_comb begin
        last_s  = last_r;
        bx_s    = bx_r;
        by_s    = by_r;
        bw_s    = bw_r;
        bh_s    = bh_r;
        col_s   = col_r;
        xc_s    = xc_r;
        yc_s    = yc_r;
        grant_s = grant_r;
        done_s  = '0;
        emit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    last_s  = pick_idx_s;
                    bx_s    = sel_x_s;
                    by_s    = sel_y_s;
                    bw_s    = sel_w_s;
                    bh_s    = sel_h_s;
                    col_s   = sel_col_s;
                    xc_s    = '0;
                    yc_s    = '0;
                    grant_s = pick_s;
                    emit_s  = ~zero_s;
                end else begin
                    grant_s = '0;
                end
            end
            DRAW: begin
                if (last_pix_s) begin
                    grant_s = '0;
                    done_s  = grant_r;
                end else if (row_end_s) begin
                    xc_s   = '0;
                    yc_s   = yc_r + ONE_DW;
                    emit_s = 1'b1;
                end else begin
                    xc_s   = xc_r + ONE_DW;
                    emit_s = 1'b1;
                end
            end
            DONE: begin
                grant_s = '0;
                done_s  = (done_r == '0) ? grant_r : '0;
            end
            default: begin
                grant_s = '0;
            end
        endcase
    end

    // Pixel coordinates are summed one bit wide so clipping sees the carry.
    assign sx_s = {1'b0, bx_s} + (XW+1)'(xc_s);
    assign sy_s = {1'b0, by_s} + (YW+1)'(yc_s);

    // Pixel outputs; coordinates hold between plots.
    always_comb begin
        if (emit_s) begin
            plot_s    = ~CLIP_ON | on_screen(sx_s, sy_s, (XW+1)'(XSCREEN), (YW+1)'(YSCREEN));
            vga_x_s   = sx_s[XW-1:0];
            vga_y_s   = sy_s[YW-1:0];
            vga_col_s = col_s;
        end else begin
            plot_s    = 1'b0;
            vga_x_s   = vga_x_r;
            vga_y_s   = vga_y_r;
            vga_col_s = vga_col_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_r    <= IW'(NREQ - 1);
            bx_r      <= '0;
            by_r      <= '0;
            bw_r      <= '0;
            bh_r      <= '0;
            col_r     <= '0;
            xc_r      <= '0;
            yc_r      <= '0;
            grant_r   <= '0;
            done_r    <= '0;
            busy_r    <= 1'b0;
            plot_r    <= 1'b0;
            vga_x_r   <= '0;
            vga_y_r   <= '0;
            vga_col_r <= '0;
        end else begin
            last_r    <= last_s;
            bx_r      <= bx_s;
            by_r      <= by_s;
            bw_r      <= bw_s;
            bh_r      <= bh_s;
            col_r     <= col_s;
            xc_r      <= xc_s;
            yc_r      <= yc_s;
            grant_r   <= grant_s;
            done_r    <= done_s;
            busy_r    <= (state_s != IDLE);
            plot_r    <= plot_s;
            vga_x_r   <= vga_x_s;
            vga_y_r   <= vga_y_s;
            vga_col_r <= vga_col_s;
        end
    end

    assign grant      = grant_r;
    assign done       = done_r;
    assign busy       = busy_r;
    assign plot       = plot_r;
    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_col_r;

endmodule

// File: tb/tb_rect_plot_arbiter.sv
// Scoreboard bench for rect_plot_arbiter; honours RECT_PLOT_CLIP_EN for expectations.
module tb_rect_plot_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 4;

    logic                Clock = 1'b0;
    logic                Reset = 1'b1;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   rect_x;
    logic [7*NREQ-1:0]   rect_y;
    logic [DW*NREQ-1:0]  rect_w;
    logic [DW*NREQ-1:0]  rect_h;
    logic [3*NREQ-1:0]   rect_colour;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     done;
    logic                busy;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [2:0]          vga_colour;
    logic                plot;

    rect_plot_arbiter #(.NREQ(NREQ), .XSCREEN(160), .YSCREEN(120), .DW(DW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req         (req),
        .rect_x      (rect_x),
        .rect_y      (rect_y),
        .rect_w      (rect_w),
        .rect_h      (rect_h),
        .rect_colour (rect_colour),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .plot        (plot)
    );

    always #5 Clock = ~Clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int plot_cnt    = 0;
    logic [17:0]     exp_pix[$];
    int              exp_done[$];
    int              got_order[$];
    int              got_cyc[$];
    logic [NREQ-1:0] prev_grant = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit visible(input int sx, input int sy);
`ifdef RECT_PLOT_CLIP_EN
        return (sx < 160) && (sy < 120);
`else
        return 1'b1;
`endif
    endfunction

    // Monitor: pop expected pixels / done pulses as the DUT produces them.
    always @(negedge Clock) begin
        cyc++;
        if (!Reset) begin
            if (plot) begin
                plot_cnt++;
                if (exp_pix.size() == 0) begin
                    check_val("plot_unexpected", 32'(plot), 32'd0);
                end else begin
                    check_val("pixel", {vga_x, vga_y, vga_colour}, exp_pix.pop_front());
                end
            end
            if (done != '0) begin
                if (exp_done.size() == 0) begin
                    check_val("done_unexpected", 32'(done), 32'd0);
                end else begin
                    check_val("done_onehot", 32'(done), 32'd1 << exp_done.pop_front());
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant[i]) got_order.push_back(i);
                end
                got_cyc.push_back(cyc);
            end
        end
        prev_grant = grant;
    end

    task automatic set_slot(input int i, input int x, input int y, input int w, input int h, input int c);
        rect_x[i*8 +: 8]       = 8'(x);
        rect_y[i*7 +: 7]       = 7'(y);
        rect_w[i*DW +: DW]     = DW'(w);
        rect_h[i*DW +: DW]     = DW'(h);
        rect_colour[i*3 +: 3]  = 3'(c);
    endtask

    task automatic push_rect(input int i, input int x, input int y, input int w, input int h,
                             input int c, output int nvis);
        nvis = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                if (visible(x + xx, y + yy)) begin
                    exp_pix.push_back({8'(x + xx), 7'(y + yy), 3'(c)});
                    nvis++;
                end
            end
        end
        exp_done.push_back(i);
    endtask

    task automatic serve(input int i, input int x, input int y, input int w, input int h,
                         input int c, input bit perturb);
        int n, nvis, dl;
        set_slot(i, x, y, w, h, c);
        push_rect(i, x, y, w, h, c, nvis);
        plot_cnt = 0;
        dl = (w == 0 || h == 0) ? 1 : w * h;
        req[i] = 1'b1;
        n = 0;
        do begin @(negedge Clock); n++; end while (grant[i] !== 1'b1 && n < 20);
        check_val("grant_latency", n, 1);
        if (perturb) rect_x[i*8 +: 8] = 8'(x + 50);
        n = 0;
        do begin @(negedge Clock); n++; end while (done[i] !== 1'b1 && n < 400);
        check_val("done_latency", n, dl);
        req[i] = 1'b0;
        check_val("plot_count", plot_cnt, nvis);
        @(negedge Clock);
        check_val("idle_gap_busy", 32'(busy), 32'd0);
        check_val("pixels_left", exp_pix.size(), 0);
    endtask

    task automatic run_multi(input logic [NREQ-1:0] mask, input int ndone);
        int k, n;
        k = 0;
        n = 0;
        req = mask;
        while (k < ndone && n < 200) begin
            @(negedge Clock);
            n++;
            if (done != '0) k++;
        end
        req = '0;
        check_val("multi_dones", k, ndone);
        repeat (3) @(negedge Clock);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #1 Reset = 1'b1;
        repeat (2) @(negedge Clock);
        #1 Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, n, nvis;
        req         = '0;
        rect_x      = '0;
        rect_y      = '0;
        rect_w      = '0;
        rect_h      = '0;
        rect_colour = '0;

        repeat (3) @(negedge Clock);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_plot", 32'(plot), 32'd0);
        check_val("rst_vga_x", 32'(vga_x), 32'd0);
        check_val("rst_vga_y", 32'(vga_y), 32'd0);
        check_val("rst_colour", 32'(vga_colour), 32'd0);
        #1 Reset = 1'b0;

        serve(0, 10, 20, 3, 2, 4, 1'b0);
        serve(1, 30, 40, 0, 5, 2, 1'b0);
        serve(2, 50, 60, 4, 3, 5, 1'b1);
        serve(0, 158, 118, 4, 4, 6, 1'b0);
        serve(1, 250, 5, 10, 1, 7, 1'b0);
        serve(2, 20, 125, 1, 5, 1, 1'b0);

        // Round robin from reset with all requesters held high.
        do_reset();
        got_order.delete();
        got_cyc.delete();
        for (int i = 0; i < NREQ; i++) set_slot(i, i*10 + 1, i*5 + 2, 1, 1, i + 1);
        for (int s = 0; s < 6; s++) push_rect(s % 3, (s % 3)*10 + 1, (s % 3)*5 + 2, 1, 1, (s % 3) + 1, nvis);
        run_multi(3'b111, 6);
        check_val("rr_count", got_order.size(), 6);
        for (int s = 0; s < 6 && s < got_order.size(); s++) check_val("rr_order", got_order[s], s % 3);
        for (int s = 1; s < 6 && s < got_cyc.size(); s++) check_val("rr_spacing", got_cyc[s] - got_cyc[s-1], 3);

        // Reset during the 4th pixel of a 5x5 rectangle.
        set_slot(0, 5, 5, 5, 5, 3);
        for (int xx = 0; xx < 4; xx++) exp_pix.push_back({8'(5 + xx), 7'(5), 3'(3)});
        req[0] = 1'b1;
        k = 0;
        n = 0;
        while (k < 4 && n < 50) begin
            @(negedge Clock);
            n++;
            if (plot) k++;
        end
        check_val("mid_plots", k, 4);
        #1 Reset = 1'b1;
        req = '0;
        @(negedge Clock);
        check_val("mid_rst_plot", 32'(plot), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_grant", 32'(grant), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        #1 Reset = 1'b0;
        check_val("mid_pixels_left", exp_pix.size(), 0);

        // Pointer must be back at NREQ-1, so requester 0 beats requester 1.
        got_order.delete();
        got_cyc.delete();
        set_slot(0, 70, 8, 1, 1, 2);
        set_slot(1, 80, 9, 1, 1, 6);
        push_rect(0, 70, 8, 1, 1, 2, nvis);
        push_rect(1, 80, 9, 1, 1, 6, nvis);
        run_multi(3'b011, 2);
        check_val("ptr_count", got_order.size(), 2);
        if (got_order.size() > 0) check_val("ptr_first", got_order[0], 0);

        check_val("done_left", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
